// File: rtl/latch_seq_pkg.sv
// Shared definitions for the latch sequence controller: FSM states, the
// fixed stimulus table and the bit positions of the latch observations.
package latch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        GRP_SR,
        GRP_JK,
        GRP_D
    } grp_e;

    localparam int unsigned NUM_STEPS = 10;
    localparam logic [3:0]  LAST_STEP = 4'(NUM_STEPS - 1);
    localparam logic [3:0]  NO_FAIL   = 4'hF;
    localparam logic [3:0]  ERR_MAX   = 4'hF;

    // obs packing: each latch contributes {qn, q}
    localparam int unsigned OBS_SR_NOR_Q   = 0;
    localparam int unsigned OBS_SR_NOR_QN  = 1;
    localparam int unsigned OBS_SR_NAND_Q  = 2;
    localparam int unsigned OBS_SR_NAND_QN = 3;
    localparam int unsigned OBS_JK_NOR_Q   = 4;
    localparam int unsigned OBS_JK_NOR_QN  = 5;
    localparam int unsigned OBS_JK_NAND_Q  = 6;
    localparam int unsigned OBS_JK_NAND_QN = 7;
    localparam int unsigned OBS_D_NOR_Q    = 8;
    localparam int unsigned OBS_D_NOR_QN   = 9;
    localparam int unsigned OBS_D_NAND_Q   = 10;
    localparam int unsigned OBS_D_NAND_QN  = 11;

    typedef struct packed {
        logic a;
        logic b;
        grp_e grp;
        logic check_en;
    } step_t;

    // Stimulus table; steps 3 and 7 drive the illegal/race input and are unchecked
    function automatic step_t step_entry(input logic [3:0] idx);
        step_t s;
        s = '{a: 1'b0, b: 1'b0, grp: GRP_SR, check_en: 1'b0};
        case (idx)
            4'd0:    s = '{a: 1'b0, b: 1'b0, grp: GRP_SR, check_en: 1'b1};
            4'd1:    s = '{a: 1'b0, b: 1'b1, grp: GRP_SR, check_en: 1'b1};
            4'd2:    s = '{a: 1'b1, b: 1'b0, grp: GRP_SR, check_en: 1'b1};
            4'd3:    s = '{a: 1'b1, b: 1'b1, grp: GRP_SR, check_en: 1'b0};
            4'd4:    s = '{a: 1'b0, b: 1'b0, grp: GRP_JK, check_en: 1'b1};
            4'd5:    s = '{a: 1'b0, b: 1'b1, grp: GRP_JK, check_en: 1'b1};
            4'd6:    s = '{a: 1'b1, b: 1'b0, grp: GRP_JK, check_en: 1'b1};
            4'd7:    s = '{a: 1'b1, b: 1'b1, grp: GRP_JK, check_en: 1'b0};
            4'd8:    s = '{a: 1'b0, b: 1'b0, grp: GRP_D,  check_en: 1'b1};
            4'd9:    s = '{a: 1'b1, b: 1'b0, grp: GRP_D,  check_en: 1'b1};
            default: s = '{a: 1'b0, b: 1'b0, grp: GRP_SR, check_en: 1'b0};
        endcase
        return s;
    endfunction

    // Number of pairs (NOR, NAND) of a group whose q equals qn
    function automatic logic [1:0] pair_fails(input logic [11:0] obs, input grp_e grp);
        logic nor_bad;
        logic nand_bad;
        case (grp)
            GRP_JK: begin
                nor_bad  = (obs[OBS_JK_NOR_Q]  == obs[OBS_JK_NOR_QN]);
                nand_bad = (obs[OBS_JK_NAND_Q] == obs[OBS_JK_NAND_QN]);
            end
            GRP_D: begin
                nor_bad  = (obs[OBS_D_NOR_Q]  == obs[OBS_D_NOR_QN]);
                nand_bad = (obs[OBS_D_NAND_Q] == obs[OBS_D_NAND_QN]);
            end
            default: begin
                nor_bad  = (obs[OBS_SR_NOR_Q]  == obs[OBS_SR_NOR_QN]);
                nand_bad = (obs[OBS_SR_NAND_Q] == obs[OBS_SR_NAND_QN]);
            end
        endcase
        return {1'b0, nor_bad} + {1'b0, nand_bad};
    endfunction

endpackage

// File: rtl/latch_settle_timer.sv
// Settle-time down-counter: loaded on entry to a drive phase, counts down
// while enabled, and flags expiry when it reaches zero.
module latch_settle_timer
    import latch_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load has priority over counting; the counter parks at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/latch_seq_ctrl.sv
// Latch test sequencer: steps through the fixed stimulus table, lets each
// stimulus settle, checks the latch outputs and accumulates the result.
module latch_seq_ctrl
    import latch_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] obs,
    output logic        a,
    output logic        b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_count,
    output logic [3:0]  first_fail
);

    // Timer holds SETTLE_CYCLES-1 so DRIVE lasts exactly SETTLE_CYCLES cycles
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e      state;
    logic [3:0]  step;
    step_t       cur_entry;
    step_t       next_entry;
    logic [1:0]  step_fails;
    logic [4:0]  err_sum;
    logic [3:0]  err_next;
    logic        timer_load;
    logic        timer_expired;

    latch_settle_timer #(
        .WIDTH (4)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .en       (state == ST_DRIVE),
        .expired  (timer_expired)
    );

    // Table lookup, masked pair check and saturating error sum for this step
    always_comb begin
        cur_entry  = step_entry(step);
        next_entry = step_entry(step + 4'd1);
        step_fails = cur_entry.check_en ? pair_fails(obs, cur_entry.grp) : 2'd0;
        err_sum    = {1'b0, err_count} + {3'b000, step_fails};
        err_next   = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[3:0];
        timer_load = 1'b0;
        if (!abort) begin
            if ((state == ST_IDLE) && start) begin
                timer_load = 1'b1;
            end else if ((state == ST_SAMPLE) && (step != LAST_STEP)) begin
                timer_load = 1'b1;
            end
        end
    end

    // Sequencer FSM with registered stimulus, status and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            step       <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= NO_FAIL;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state      <= ST_DRIVE;
                        step       <= '0;
                        a          <= step_entry(4'd0).a;
                        b          <= step_entry(4'd0).b;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= NO_FAIL;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                    end else if (timer_expired) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        err_count <= err_next;
                        if ((step_fails != 2'd0) && (first_fail == NO_FAIL)) begin
                            first_fail <= step;
                        end
                        if (step == LAST_STEP) begin
                            state <= ST_DONE;
                            a     <= 1'b0;
                            b     <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DRIVE;
                            step  <= step + 4'd1;
                            a     <= next_entry.a;
                            b     <= next_entry.b;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                end
                default: begin
                    state <= ST_IDLE;
                    a     <= 1'b0;
                    b     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_seq_ctrl.sv
// Bench for latch_seq_ctrl: fixed-pattern table, corner-case sequences
// (start while busy, abort, start+abort, mid-run reset) and random
// observation runs scored against a step-arithmetic reference model.
module tb_latch_seq_ctrl;

    localparam int S   = 4;
    localparam int P   = S + 1;
    localparam int RUN = 10 * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [11:0] obs;
    logic        a;
    logic        b;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  err_count;
    logic [3:0]  first_fail;

    int checks   = 0;
    int failures = 0;

    latch_seq_ctrl #(
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .obs        (obs),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] obs;
        int          err;
        int          ff;
        logic        pass;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected {a,b} for a step: SR/JK walk 00,01,10,11; D uses 00,10
    function automatic int exp_ab(input int step);
        if (step < 8) return step % 4;
        return (step - 8) * 2;
    endfunction

    // Failed pairs at a step: group g owns obs[4g+3:4g], pairs {4g+1,4g} and {4g+3,4g+2}
    function automatic int step_fails(input int step, input logic [11:0] o);
        int base;
        int n;
        if (step == 3 || step == 7) return 0;
        base = 4 * (step / 4);
        n = 0;
        if (o[base] == o[base+1]) n++;
        if (o[base+2] == o[base+3]) n++;
        return n;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_outs"}, int'({a, b, busy, done}), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_ff"}, int'(first_fail), 15);
    endtask

    // One run from an idle DUT; optional start poke, abort or reset at cycle k
    task automatic run_seq(input bit rnd, input logic [11:0] fix, input int poke,
                           input int abort_at, input int rst_at);
        int   step;
        int   phase;
        int   ab;
        int   busy_e;
        int   done_e;
        int   m_err;
        int   m_ff;
        int   f;
        logic pass_e;
        m_err = 0;
        m_ff  = 15;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= RUN + 2; k++) begin
            step  = k / P;
            phase = k % P;
            if (k < RUN) begin
                ab = exp_ab(step); busy_e = 1; done_e = 0;
            end else begin
                ab = 0; busy_e = 0; done_e = (k == RUN + 1) ? 1 : 0;
            end
            pass_e = (k >= RUN + 1) && (m_err == 0);
            check("a_b_busy_done", int'({a, b, busy, done}), (ab << 2) | (busy_e << 1) | done_e);
            check("err_count", int'(err_count), m_err);
            check("first_fail", int'(first_fail), m_ff);
            check("pass", int'(pass), int'(pass_e));
            if (k == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                repeat (12) begin
                    check("abort_outs", int'({a, b, busy, done}), 0);
                    check("abort_err", int'(err_count), m_err);
                    check("abort_ff", int'(first_fail), m_ff);
                    check("abort_pass", int'(pass), 0);
                    tick();
                end
                return;
            end
            if (k == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check_reset_vals("midrun_rst");
                #1 rst = 1'b0;
                return;
            end
            obs   = rnd ? 12'($urandom) : fix;
            start = (k == poke);
            if (k < RUN && phase == S) begin
                f = step_fails(step, obs);
                if (f > 0 && m_ff == 15) m_ff = step;
                m_err = (m_err + f > 15) ? 15 : m_err + f;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        // pattern, expected err_count, first_fail, pass
        vecs[0] = '{12'hAAA, 0,  15, 1'b1};  // all pairs complementary
        vecs[1] = '{12'hAAB, 3,  0,  1'b0};  // SR NOR q==qn=1
        vecs[2] = '{12'h000, 15, 0,  1'b0};  // every pair equal: 16 failures
        vecs[3] = '{12'hFFF, 15, 0,  1'b0};
        vecs[4] = '{12'hAEA, 3,  4,  1'b0};  // JK NAND stuck equal
        vecs[5] = '{12'hBAA, 2,  8,  1'b0};  // D NOR stuck equal
        vecs[6] = '{12'hAA2, 3,  0,  1'b0};  // SR NAND q==qn=0

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        obs   = 12'hAAA;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check_reset_vals("post_reset_idle");

        for (int i = 0; i < 7; i++) begin
            run_seq(1'b0, vecs[i].obs, -1, -1, -1);
            check($sformatf("vec%0d_err", i), int'(err_count), vecs[i].err);
            check($sformatf("vec%0d_ff", i), int'(first_fail), vecs[i].ff);
            check($sformatf("vec%0d_pass", i), int'(pass), int'(vecs[i].pass));
        end

        // start pulse at cycle 20 of a clean run must be ignored
        run_seq(1'b0, 12'hAAA, 20, -1, -1);
        check("busy_start_pass", int'(pass), 1);

        // start and abort together in IDLE: not accepted, result held
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        check("start_abort_pass", int'(pass), 1);
        tick();
        check("start_abort_idle", int'({a, b, busy, done}), 0);

        // abort during step 5 DRIVE with an SR NOR fault already counted
        run_seq(1'b0, 12'hAAB, -1, 5 * P + 1, -1);
        check("abort_final_err", int'(err_count), 3);
        check("abort_final_ff", int'(first_fail), 0);

        // reset during step 2, then a normal run
        run_seq(1'b0, 12'hAAB, -1, -1, 2 * P + 1);
        run_seq(1'b0, 12'hAAA, -1, -1, -1);
        check("after_rst_pass", int'(pass), 1);

        for (int r = 0; r < 8; r++) begin
            run_seq(1'b1, 12'h000, -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
